mem_access_unit: RTL and testbench

//  MEM-stage load/store engine; consumes the EX/MEM pipeline register outputs (mem_*).

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 87 ++++++++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage load/store engine.
//  - aluop codes for the eight load/store operations
//  - FSM state encoding used by mem_access_unit
package mem_pkg;

    localparam logic [5:0] EXE_LB_OP  = 6'h20;
    localparam logic [5:0] EXE_LH_OP  = 6'h21;
    localparam logic [5:0] EXE_LW_OP  = 6'h23;
    localparam logic [5:0] EXE_LBU_OP = 6'h24;
    localparam logic [5:0] EXE_LHU_OP = 6'h25;
    localparam logic [5:0] EXE_SB_OP  = 6'h28;
    localparam logic [5:0] EXE_SH_OP  = 6'h29;
    localparam logic [5:0] EXE_SW_OP  = 6'h2B;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for big-endian byte/halfword/word accesses.
// Ports:
//  aluop       in   6   operation code
//  addr_lo     in   2   effective address bits [1:0]
//  store_data  in   32  raw store operand
//  load_word   in   32  captured bus read word
//  is_load     out  1   op is a load
//  is_store    out  1   op is a store
//  misaligned  out  1   misaligned half/word (only with MEM_ALIGN_CHECK_EN)
//  be          out  4   byte enables, bit3 = bits[31:24]
//  wdata       out  32  lane-replicated store data
//  load_data   out  32  extracted and extended load result
// Config: MEM_ALIGN_CHECK_EN enables misalignment detection; otherwise low
// address bits are ignored for words and addr_lo[0] is ignored for halves.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [5:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        is_load,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  byte_be;
    logic [3:0]  half_be;
    logic        is_half;
    logic        is_word;

    // Address 0 selects the most significant lane.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = load_word[31:24];
            2'd1:    byte_v = load_word[23:16];
            2'd2:    byte_v = load_word[15:8];
            default: byte_v = load_word[7:0];
        endcase
    end

    assign half_v  = addr_lo[1] ? load_word[15:0] : load_word[31:16];
    assign byte_be = 4'b1000 >> addr_lo;
    assign half_be = addr_lo[1] ? 4'b0011 : 4'b1100;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        be        = 4'h0;
        wdata     = store_data;
        load_data = load_word;
        case (aluop)
            EXE_LB_OP:  begin is_load = 1'b1; be = byte_be; load_data = {{24{byte_v[7]}}, byte_v}; end
            EXE_LBU_OP: begin is_load = 1'b1; be = byte_be; load_data = {24'h0, byte_v}; end
            EXE_LH_OP:  begin
                is_load = 1'b1; is_half = 1'b1; be = half_be;
                load_data = {{16{half_v[15]}}, half_v};
            end
            EXE_LHU_OP: begin
                is_load = 1'b1; is_half = 1'b1; be = half_be;
                load_data = {16'h0, half_v};
            end
            EXE_LW_OP:  begin is_load = 1'b1; is_word = 1'b1; be = 4'hF; end
            EXE_SB_OP:  begin is_store = 1'b1; be = byte_be; wdata = {4{store_data[7:0]}}; end
            EXE_SH_OP:  begin
                is_store = 1'b1; is_half = 1'b1; be = half_be;
                wdata = {2{store_data[15:0]}};
            end
            EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; be = 4'hF; end
            default:    ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'd0));
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine driving a req/ack data bus.
// Ports:
//  clk, rst                 clock and synchronous active-high reset
//  mem_*                    EX/MEM register outputs (wd, wreg, wdata, whilo, hi, lo,
//                           aluop, mem_addr, reg2)
//  dbus_rdata, dbus_ack     bus read data and one-cycle completion pulse
//  dbus_req/we/addr/be/wdata registered bus request
//  stall_req                freezes the upstream pipeline during an access
//  wb_*                     results to the MEM/WB register
//  excp_align               misaligned access flag
// Config: MEM_ALIGN_CHECK_EN (see mem_lane_align) enables alignment checking.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic [5:0]        mem_aluop,
    input  logic [ADDR_W-1:0] mem_mem_addr,
    input  logic [DATA_W-1:0] mem_reg2,
    input  logic [DATA_W-1:0] dbus_rdata,
    input  logic              dbus_ack,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [DATA_W-1:0] dbus_wdata,
    output logic              stall_req,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              excp_align
);

    logic [1:0]        state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_buf_q;

    logic              is_load;
    logic              is_store;
    logic              misaligned;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] load_data;
    logic              start;

    mem_lane_align u_lane_align (
        .aluop      (mem_aluop),
        .addr_lo    (mem_mem_addr[1:0]),
        .store_data (mem_reg2),
        .load_word  (load_buf_q),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    // A misaligned op (only possible with checking enabled) never reaches the bus.
    assign start = (is_load | is_store) & ~misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
            load_buf_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
                        be_q    <= lane_be;
                        wdata_q <= lane_wdata;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        state_q    <= DONE;
                        req_q      <= 1'b0;
                        load_buf_q <= dbus_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;
    assign excp_align = misaligned;

    assign stall_req = (state_q == BUSY) | ((state_q == IDLE) & start);

    always_comb begin
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg & ~misaligned;
        wb_wdata = mem_wdata;
        wb_whilo = mem_whilo;
        wb_hi    = mem_hi;
        wb_lo    = mem_lo;
        if (state_q == DONE) begin
            if (is_load) begin
                wb_wdata = load_data;
            end
            if (is_store) begin
                wb_wreg = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [5:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        stall_req;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        excp_align;

    int n_tests = 0;
    int n_fail  = 0;

    // Values observed during the last access, checked by the caller.
    logic        issue_stall, issue_req, busy_req, busy_we, ack_stall;
    logic [31:0] busy_addr, busy_wdata;
    logic [3:0]  busy_be;

    mem_access_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .dbus_rdata   (dbus_rdata),
        .dbus_ack     (dbus_ack),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_be      (dbus_be),
        .dbus_wdata   (dbus_wdata),
        .stall_req    (stall_req),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .wb_whilo     (wb_whilo),
        .wb_hi        (wb_hi),
        .wb_lo        (wb_lo),
        .excp_align   (excp_align)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop(input logic [31:0] wdata);
        mem_aluop    = 6'h02;
        mem_wdata    = wdata;
        mem_mem_addr = 32'h0;
        mem_reg2     = 32'h0;
    endtask

    // Runs one access: returns with the unit in DONE and the op still applied.
    task automatic mem_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] rdata,
                          input int ack_wait);
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        #1;
        issue_stall = stall_req;
        issue_req   = dbus_req;
        tick();
        busy_req   = dbus_req;
        busy_we    = dbus_we;
        busy_addr  = dbus_addr;
        busy_be    = dbus_be;
        busy_wdata = dbus_wdata;
        for (int i = 0; i < ack_wait; i++) tick();
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
        #1;
        ack_stall = stall_req;
        tick();
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        #1;
    endtask

    task automatic load_case(input string tag, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        mem_op(op, addr, 32'h0, rdata, 0);
        check(tag, wb_wdata, exp);
        set_nop(32'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        mem_wd = 5'd0; mem_wreg = 1'b0; mem_whilo = 1'b0;
        mem_hi = 32'h0; mem_lo = 32'h0;
        set_nop(32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_req", {31'h0, dbus_req}, 32'h0);
        check("rst_we", {31'h0, dbus_we}, 32'h0);
        check("rst_addr", dbus_addr, 32'h0);
        check("rst_be", {28'h0, dbus_be}, 32'h0);
        check("rst_wdata", dbus_wdata, 32'h0);
        check("rst_stall", {31'h0, stall_req}, 32'h0);

        // Pass-through
        mem_wd = 5'd5; mem_wreg = 1'b1; mem_whilo = 1'b1;
        mem_hi = 32'h1111_2222; mem_lo = 32'h3333_4444;
        set_nop(32'h1234);
        #1;
        check("pt_wdata", wb_wdata, 32'h1234);
        check("pt_wd", {27'h0, wb_wd}, 32'd5);
        check("pt_wreg", {31'h0, wb_wreg}, 32'h1);
        check("pt_hi", wb_hi, 32'h1111_2222);
        check("pt_lo", wb_lo, 32'h3333_4444);
        check("pt_whilo", {31'h0, wb_whilo}, 32'h1);
        check("pt_stall", {31'h0, stall_req}, 32'h0);
        tick();
        check("pt_noreq", {31'h0, dbus_req}, 32'h0);
        mem_whilo = 1'b0;

        // LW with ack after 3 cycles
        mem_wd = 5'd3;
        mem_op(6'h23, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
        check("lw_issue_stall", {31'h0, issue_stall}, 32'h1);
        check("lw_issue_noreq", {31'h0, issue_req}, 32'h0);
        check("lw_req", {31'h0, busy_req}, 32'h1);
        check("lw_we", {31'h0, busy_we}, 32'h0);
        check("lw_addr", busy_addr, 32'h100);
        check("lw_be", {28'h0, busy_be}, 32'hF);
        check("lw_ack_stall", {31'h0, ack_stall}, 32'h1);
        check("lw_done_stall", {31'h0, stall_req}, 32'h0);
        check("lw_done_req", {31'h0, dbus_req}, 32'h0);
        check("lw_wdata", wb_wdata, 32'hDEAD_BEEF);
        check("lw_wreg", {31'h0, wb_wreg}, 32'h1);
        set_nop(32'h55);
        tick();
        check("lw_idle_stall", {31'h0, stall_req}, 32'h0);
        check("lw_idle_wdata", wb_wdata, 32'h55);

        // Byte / halfword loads
        mem_op(6'h20, 32'h103, 32'h0, 32'h0000_00F0, 1);
        check("lb_be", {28'h0, busy_be}, 32'h1);
        check("lb_addr", busy_addr, 32'h100);
        check("lb_sext", wb_wdata, 32'hFFFF_FFF0);
        set_nop(32'h0);
        tick();
        load_case("lbu_zext", 6'h24, 32'h103, 32'h0000_00F0, 32'h0000_00F0);
        load_case("lb_lane0", 6'h20, 32'h100, 32'h80AA_BBCC, 32'hFFFF_FF80);
        load_case("lbu_lane1", 6'h24, 32'h101, 32'h80AA_BBCC, 32'h0000_00AA);
        load_case("lh_hi_lane", 6'h21, 32'h102, 32'h1234_8001, 32'hFFFF_8001);
        load_case("lhu_lo_lane", 6'h25, 32'h100, 32'h8001_1234, 32'h0000_8001);

        // Stores
        mem_wreg = 1'b1;
        mem_wdata = 32'h9999;
        mem_op(6'h29, 32'h202, 32'h0000_ABCD, 32'h0, 2);
        check("sh_we", {31'h0, busy_we}, 32'h1);
        check("sh_be", {28'h0, busy_be}, 32'h3);
        check("sh_wdata", busy_wdata, 32'hABCD_ABCD);
        check("sh_addr", busy_addr, 32'h200);
        check("sh_wreg", {31'h0, wb_wreg}, 32'h0);
        check("sh_stall", {31'h0, stall_req}, 32'h0);
        set_nop(32'h0);
        tick();
        mem_op(6'h28, 32'h201, 32'h0000_005A, 32'h0, 0);
        check("sb_be", {28'h0, busy_be}, 32'h4);
        check("sb_wdata", busy_wdata, 32'h5A5A_5A5A);
        set_nop(32'h0);
        tick();

        // Reset mid-BUSY, late ack ignored
        mem_aluop = 6'h23; mem_mem_addr = 32'h300;
        tick();
        check("rb_busy_req", {31'h0, dbus_req}, 32'h1);
        tick();
        rst = 1'b1;
        set_nop(32'h77);
        tick();
        rst = 1'b0;
        #1;
        check("rb_req_after_rst", {31'h0, dbus_req}, 32'h0);
        dbus_ack = 1'b1; dbus_rdata = 32'h0BAD_0BAD;
        tick();
        dbus_ack = 1'b0; dbus_rdata = 32'h0;
        #1;
        check("rb_req_late_ack", {31'h0, dbus_req}, 32'h0);
        check("rb_stall", {31'h0, stall_req}, 32'h0);
        check("rb_wdata", wb_wdata, 32'h77);
        tick();
        check("rb_still_idle", {31'h0, stall_req}, 32'h0);
        // A subsequent LBU must see fresh bus data, not the discarded ack data.
        load_case("rb_next_load", 6'h24, 32'h103, 32'h0000_0042, 32'h0000_0042);

        // Misaligned word
        mem_wreg = 1'b1;
        mem_aluop = 6'h23; mem_mem_addr = 32'h101;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        check("al_excp", {31'h0, excp_align}, 32'h1);
        check("al_wreg", {31'h0, wb_wreg}, 32'h0);
        check("al_stall", {31'h0, stall_req}, 32'h0);
        tick();
        check("al_noreq", {31'h0, dbus_req}, 32'h0);
        set_nop(32'h0);
        tick();
`else
        check("al_excp_tied", {31'h0, excp_align}, 32'h0);
        check("al_stall", {31'h0, stall_req}, 32'h1);
        mem_op(6'h23, 32'h101, 32'h0, 32'hCAFE_F00D, 0);
        check("al_addr", busy_addr, 32'h100);
        check("al_be", {28'h0, busy_be}, 32'hF);
        check("al_wdata", wb_wdata, 32'hCAFE_F00D);
        set_nop(32'h0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
